// File: rtl/dmem_obi_responder.sv
// dmem_obi_responder
// Single-port data memory behind an OBI-style request/grant/response handshake.
// Each request is stalled for WAIT_CYCLES cycles, granted, and answered with a
// one-cycle response. At most one transaction is outstanding at a time.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   data_req_i      request valid
//   data_addr_i     byte address
//   data_we_i       1 = write, 0 = read
//   data_be_i       byte enables (writes only)
//   data_wdata_i    write data
//   data_gnt_o      request accepted on this rising edge
//   data_rvalid_o   response valid (one cycle after accept)
//   data_rdata_o    read data (0 outside the response cycle, on writes and on errors)
//   data_err_o      misaligned or out-of-range access
//
// state | meaning
// IDLE  | no transaction; a new request is granted at once or starts a stall
// STALL | request pending, counter counts down to the grant cycle
// RESP  | response cycle; a new request is handled exactly as in IDLE
module dmem_obi_responder #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          DEPTH       = 256,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    data_req_i,
   input  logic [31:0]             data_addr_i,
   input  logic                    data_we_i,
   input  logic [3:0]              data_be_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic                    data_err_o
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
   localparam logic [3:0]  WAIT_M1 = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, STALL, RESP} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    gnt;
   logic                    accept;
   logic                    addr_err;
   logic [AW-1:0]           idx;

   always_comb begin
      idx      = AW'((data_addr_i - BASE_ADDR) >> 2);
      addr_err = (data_addr_i[1:0] != 2'b00) ||
                 (data_addr_i < BASE_ADDR) ||
                 ({1'b0, data_addr_i} >= LIMIT);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            if (data_req_i) begin
               if (WAIT_CYCLES == 0) begin
                  gnt     = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = STALL;
                  cnt_d   = WAIT_M1;
               end
            end
         end
         STALL: begin
            if (!data_req_i) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               gnt     = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // The grant is gated by reset so that a zero-wait instance held in reset
   // neither grants nor writes memory while a request is pending.
   assign data_gnt_o = gnt & rst_n;
   assign accept     = data_req_i & data_gnt_o;

   always_comb begin
      rdata_d = '0;
      err_d   = 1'b0;
      if (accept) begin
         if (addr_err) begin
            err_d = 1'b1;
         end else if (!data_we_i) begin
            rdata_d = mem_q[idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Memory is deliberately not reset; contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (accept && data_we_i && !addr_err) begin
         for (int k = 0; k < 4; k++) begin
            if (data_be_i[k]) mem_q[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
         end
      end
   end

   // rdata_q/err_q are only non-zero in the cycle after an accept, which is RESP.
   assign data_rvalid_o = (state_q == RESP);
   assign data_rdata_o  = rdata_q;
   assign data_err_o    = err_q;

endmodule

// File: tb/tb_dmem_obi_responder.sv
// Testbench for dmem_obi_responder: three instances (WAIT_CYCLES 1, 0, 3)
// share one stimulus bus; only the selected instance sees data_req_i.
module tb_dmem_obi_responder;

   localparam logic [31:0] BASE = 32'h0;
   localparam int          DEP  = 256;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  sel = 2'd0;

   logic [2:0]  req_v;
   logic [2:0]  gnt_a;
   logic [2:0]  rvalid_a;
   logic [2:0]  err_a;
   logic [31:0] rdata_a [3];

   logic        gnt_m, rvalid_m, err_m;
   logic [31:0] rdata_m;

   logic [31:0] ref_mem [3][DEP];
   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;

   function automatic logic [31:0] init_val(input int k, input int i);
      logic [31:0] v;
      logic [31:0] kk;
      v  = 32'(i + 1) * 32'h9E3779B9;
      kk = 32'(k);
      return v ^ {kk[3:0], 28'h0};
   endfunction

   function automatic int wait_of(input logic [1:0] s);
      return (s == 2'd0) ? 1 : ((s == 2'd1) ? 0 : 3);
   endfunction

   assign req_v    = req ? (3'b001 << sel) : 3'b000;
   assign gnt_m    = gnt_a[sel];
   assign rvalid_m = rvalid_a[sel];
   assign err_m    = err_a[sel];
   assign rdata_m  = rdata_a[sel];

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int W = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
      dmem_obi_responder #(
         .DATA_WIDTH(32), .DEPTH(DEP), .WAIT_CYCLES(W), .BASE_ADDR(BASE)
      ) u (
         .clk(clk), .rst_n(rst_n),
         .data_req_i(req_v[k]), .data_addr_i(addr), .data_we_i(we),
         .data_be_i(be), .data_wdata_i(wdata),
         .data_gnt_o(gnt_a[k]), .data_rvalid_o(rvalid_a[k]),
         .data_rdata_o(rdata_a[k]), .data_err_o(err_a[k])
      );
      initial begin
         for (int i = 0; i < DEP; i++) u.mem_q[i] = init_val(k, i);
      end
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Reference model: applies a granted transaction and returns its response.
   task automatic model(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output exp_t e);
      int          i;
      logic [32:0] hi;
      hi      = {1'b0, BASE} + 33'(4 * DEP);
      e.rdata = 32'h0;
      e.err   = 1'b0;
      e.cyc   = cyc + 1;
      if (a[1:0] != 2'b00 || a < BASE || {1'b0, a} >= hi) begin
         e.err = 1'b1;
      end else begin
         i = int'((a - BASE) / 4);
         if (w) begin
            for (int k = 0; k < 4; k++)
               if (b[k]) ref_mem[sel][i][8*k +: 8] = d[8*k +: 8];
         end else begin
            e.rdata = ref_mem[sel][i];
         end
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accept edge with
   // req still high so a following issue() runs back-to-back.
   task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
      int   lat;
      bit   got;
      exp_t e;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      lat = 0; got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (gnt_m) got = 1'b1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL grant_timeout: sel=%0d addr=%h no grant after %0d cycles", sel, a, lat);
         req = 1'b0;
         return;
      end
      if (lat != wait_of(sel)) begin
         bad++;
         $display("FAIL grant_latency: sel=%0d addr=%h got %0d cycles, want %0d", sel, a, lat, wait_of(sel));
      end
      model(w, a, b, d, e);
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rvalid_m) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_rvalid: sel=%0d cyc=%0d rdata=%h err=%b", sel, cyc, rdata_m, err_m);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (rdata_m !== e.rdata || err_m !== e.err || cyc != e.cyc) begin
                  bad++;
                  $display("FAIL response: sel=%0d got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                           sel, rdata_m, err_m, cyc, e.rdata, e.err, e.cyc);
               end
            end
         end else begin
            total++;
            if (rdata_m !== 32'h0 || err_m !== 1'b0) begin
               bad++;
               $display("FAIL idle_outputs: sel=%0d rdata=%h err=%b, want 0/0", sel, rdata_m, err_m);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               exp_t e;
               e = exp_q.pop_front();
               total++;
               bad++;
               $display("FAIL missing_rvalid: sel=%0d rvalid=0 at cyc %0d, want 1 (rdata=%h)", sel, e.cyc, e.rdata);
            end
         end
      end
   end

   initial begin
      logic [31:0] a;
      int          r;
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < DEP; i++) ref_mem[k][i] = init_val(k, i);

      // Outputs held at zero in reset, even with a request pending.
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         req = 1'b1;
         @(negedge clk);
         check1("reset_outputs", {29'h0, gnt_m, rvalid_m, err_m}, 32'h0);
         check1("reset_rdata", rdata_m, 32'h0);
         @(posedge clk); #1;
         req = 1'b0;
      end
      sel = 2'd0;
      rst_n = 1'b1;
      mon_en = 1'b1;
      idle(2);

      // WAIT_CYCLES=1: write/read, byte merge, errors.
      issue(1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
      idle(1);
      issue(1'b0, 32'h8, 4'h0, 32'h0);
      issue(1'b1, 32'h10, 4'hF, 32'h11223344);
      issue(1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
      issue(1'b0, 32'h10, 4'hF, 32'h0);
      issue(1'b0, 32'h3, 4'hF, 32'h0);
      issue(1'b0, 32'h400, 4'hF, 32'h0);
      issue(1'b1, 32'h402, 4'hF, 32'hFFFFFFFF);
      issue(1'b0, 32'h0, 4'hF, 32'h0);
      issue(1'b1, 32'h14, 4'h0, 32'h12345678);
      issue(1'b0, 32'h14, 4'hF, 32'h0);
      idle(3);

      // WAIT_CYCLES=0: back-to-back reads.
      sel = 2'd1;
      issue(1'b0, 32'h0, 4'hF, 32'h0);
      issue(1'b0, 32'h4, 4'hF, 32'h0);
      issue(1'b0, 32'h8, 4'hF, 32'h0);
      idle(3);

      // WAIT_CYCLES=3: request withdrawn after one cycle.
      sel = 2'd2;
      req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'hCAFEF00D;
      @(negedge clk);
      check1("drop_no_gnt", {31'h0, gnt_m}, 32'h0);
      @(posedge clk); #1;
      req = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check1("drop_idle_gnt", {31'h0, gnt_m}, 32'h0);
      end
      @(posedge clk); #1;
      issue(1'b0, 32'h20, 4'hF, 32'h0);
      idle(3);

      // Reset pulse during the response cycle aborts it.
      sel = 2'd0;
      issue(1'b0, 32'h8, 4'hF, 32'h0);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check1("reset_rvalid", {31'h0, rvalid_m}, 32'h0);
      sel = 2'd1;
      #1;
      check1("reset_gnt_w0", {31'h0, gnt_m}, 32'h0);
      sel = 2'd0;
      @(posedge clk); #1;
      req = 1'b0;
      rst_n = 1'b1;
      idle(4);
      issue(1'b0, 32'h8, 4'hF, 32'h0);
      issue(1'b0, 32'h10, 4'hF, 32'h0);
      idle(2);

      // Randomized traffic on every instance.
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         for (int t = 0; t < 60; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            else if (r == 7) a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (r == 8) a = 32'h400 + 32'(4 * $urandom_range(0, 63));
            else             a = $urandom;
            issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
            r = int'($urandom_range(0, 2));
            if (r != 0) idle(r);
         end
         idle(4);
      end

      idle(5);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pending_at_end: %0d responses outstanding, want 0", exp_q.size());
      end
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_obi_responder.md
DMEM_OBI_RESPONDER -- requirements
Module: dmem_obi_responder

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32: data bus width; only 32 is supported.
- DEPTH, default 256: number of words in the memory.
- WAIT_CYCLES, default 1, range 0..15: stall cycles from request to grant.
- BASE_ADDR, default 32'h0: byte address of word 0.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n as elsewhere in the codebase.
REQ-003 Ports (clock and reset first):
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- data_req_i  input  1  request valid
- data_addr_i  input  32  byte address
- data_we_i  input  1  1 = write, 0 = read
- data_be_i  input  4  byte enables
- data_wdata_i  input  32  write data
- data_gnt_o  output  1  request accepted
- data_rvalid_o  output  1  response valid
- data_rdata_o  output  32  read data
- data_err_o  output  1  response error

Function
REQ-004 The FSM SHALL have states IDLE, STALL and RESP, with at most one outstanding transaction.
REQ-005 In IDLE with data_req_i=1:
- WAIT_CYCLES=0: data_gnt_o=1 combinationally in the same cycle.
- Otherwise: load the stall counter with WAIT_CYCLES-1 and go to STALL; data_gnt_o=0.
REQ-006 In STALL, the counter SHALL decrement each cycle. data_gnt_o SHALL equal data_req_i when the counter is 0. The request is accepted on the next rising edge.
REQ-007 A request is accepted on any rising edge where data_req_i=1 and data_gnt_o=1. The FSM then enters RESP for exactly one cycle.
REQ-008 In RESP, data_rvalid_o=1 for exactly one cycle, with data_rdata_o and data_err_o valid in that cycle.
REQ-009 A new request in the RESP cycle SHALL be handled as in IDLE; with WAIT_CYCLES=0 it is granted in that cycle, giving back-to-back rvalid.
REQ-010 After RESP with no new grant, the FSM goes to IDLE or STALL per REQ-005.
REQ-011 If data_req_i drops in STALL before grant, the FSM SHALL return to IDLE with no memory access and no response.
REQ-012 Error condition: data_addr_i[1:0]!=0, data_addr_i<BASE_ADDR, or data_addr_i>=BASE_ADDR+4*DEPTH.
REQ-013 On error, the response SHALL carry data_err_o=1 and data_rdata_o=0, and memory SHALL NOT be modified.
REQ-014 Word index = (data_addr_i-BASE_ADDR)>>2, truncated to $clog2(DEPTH) bits.
REQ-015 An accepted non-error write SHALL update byte k of the addressed word iff data_be_i[k]=1, at the accept edge. Response: rdata=0, err=0.
REQ-016 An accepted non-error read SHALL return the full 32-bit word as it stood before the accept edge, ignoring data_be_i. Response: err=0.
REQ-017 A write with data_be_i=4'b0000 SHALL be a legal no-op with a normal response.
REQ-018 Outside RESP, data_rdata_o=0 and data_err_o=0.

Reset
REQ-019 While rst_n=0, outputs SHALL be: data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0; state=IDLE; counter=0.
REQ-020 Reset asserted mid-transaction (STALL or RESP) SHALL abort it; no response follows after reset release.
REQ-021 Memory contents SHALL NOT be reset; the testbench preloads them hierarchically.
REQ-022 data_gnt_o SHALL be 0 while rst_n=0 even if data_req_i=1.

Verification
REQ-023 Scenarios the bench SHALL cover:
- WAIT_CYCLES=1, write 0xDEADBEEF to 0x8 with be=4'hF, then read 0x8 -> gnt one cycle after req; rvalid the cycle after gnt; rdata=0xDEADBEEF, err=0.
- Byte-enable merge: word 0x11223344 at 0x10; write 0xAABBCCDD with be=4'b0101 -> readback 0x11BB33DD.
- Errors: read 0x3 and read 0x400 (DEPTH=256) -> err=1, rdata=0; a write to 0x402 leaves memory unchanged.
- WAIT_CYCLES=0, three back-to-back reads of 0x0, 0x4, 0x8 -> gnt on every cycle; rvalid on three consecutive cycles, in order.
- WAIT_CYCLES=3, req dropped after one cycle -> no gnt, no rvalid, FSM back in IDLE.
- rst_n pulsed low during RESP -> rvalid=0 immediately; no response after release; memory contents retained.
